// File: rtl/l_func_ctrl_if.sv
// l_func_ctrl_if -- bundle of every l_func_ctrl signal except clk/rst_n.
//   Upstream  : in_valid/in_ready handshake carrying in_x, in_n beats.
//   Divider   : div_valid_in start pulse, div_data_vld stream with
//               div_dividend/div_divisor, quotient return div_q/div_q_vld.
//   Downstream: out_data/out_valid, done, underflow, err.
// Modports: slave = the l_func_ctrl side, master = its environment.
interface l_func_ctrl_if #(
    parameter int unsigned BLOCK = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [BLOCK-1:0] in_x;
    logic [BLOCK-1:0] in_n;
    logic             div_valid_in;
    logic             div_data_vld;
    logic [BLOCK-1:0] div_dividend;
    logic [BLOCK-1:0] div_divisor;
    logic [BLOCK-1:0] div_q;
    logic             div_q_vld;
    logic [BLOCK-1:0] out_data;
    logic             out_valid;
    logic             done;
    logic             underflow;
    logic             err;

    modport slave (
        input  in_valid, in_x, in_n, div_q, div_q_vld,
        output in_ready, div_valid_in, div_data_vld, div_dividend, div_divisor,
               out_data, out_valid, done, underflow, err
    );

    modport master (
        output in_valid, in_x, in_n, div_q, div_q_vld,
        input  in_ready, div_valid_in, div_data_vld, div_dividend, div_divisor,
               out_data, out_valid, done, underflow, err
    );
endinterface

// File: rtl/l_func_ctrl.sv
// l_func_ctrl -- sequencer for the Paillier L-function L(x) = (x - 1) / n
// around a shared streaming divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   io (slave) : upstream x/n beats (LSB first, x - 1 formed on the fly with a
//                rippled borrow), divider start pulse + contiguous NCNT-beat
//                operand stream, MCNT quotient beats forwarded downstream,
//                done pulse with underflow (x was 0).
// Optional: define L_FUNC_WATCHDOG_EN to enable a WAIT-state watchdog that
// aborts the job with a one-cycle err pulse after TIMEOUT idle cycles;
// otherwise err is tied 0 and WAIT waits indefinitely.
module l_func_ctrl #(
    parameter int unsigned N       = 4096,
    parameter int unsigned M       = 2048,
    parameter int unsigned BLOCK   = 128,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    l_func_ctrl_if.slave  io
);
    localparam int unsigned NCNT = N / BLOCK;
    localparam int unsigned MCNT = M / BLOCK;
    localparam int unsigned IW   = $clog2(NCNT);
    localparam int unsigned JW   = $clog2(MCNT);
    localparam int unsigned CW   = IW + 1;
    localparam logic [CW-1:0] NLAST_C = CW'(NCNT - 1);
    localparam logic [CW-1:0] MCNT_C  = CW'(MCNT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        STREAM,
        WAIT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             underflow_q, underflow_d;
    logic             in_ready_q, in_ready_d;
    logic [BLOCK-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic [BLOCK-1:0] x_buf_q [NCNT];
    logic [BLOCK-1:0] n_buf_q [MCNT];

    logic             accept;
    logic             borrow_in;
    logic             x_we;
    logic             n_we;
    logic [BLOCK-1:0] x_wr;
    logic             err_w;

`ifdef L_FUNC_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;
`endif

    // in_ready_q is only high in IDLE/LOAD, so it doubles as the state gate.
    assign accept    = io.in_valid && in_ready_q;
    // Beat 0 always starts with a borrow of 1 (the "- 1").
    assign borrow_in = (state_q == IDLE) ? 1'b1 : borrow_q;
    assign x_wr      = io.in_x - BLOCK'(borrow_in);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        borrow_d    = borrow_q;
        underflow_d = underflow_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        x_we        = 1'b0;
        n_we        = 1'b0;
        err_w       = 1'b0;
`ifdef L_FUNC_WATCHDOG_EN
        wd_d        = '0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_we        = 1'b1;
                    n_we        = 1'b1;
                    underflow_d = 1'b0;
                    borrow_d    = (io.in_x == '0);
                    cnt_d       = CW'(1);
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    x_we     = 1'b1;
                    n_we     = (cnt_q < MCNT_C);
                    borrow_d = borrow_q && (io.in_x == '0);
                    if (cnt_q == NLAST_C) begin
                        underflow_d = borrow_q && (io.in_x == '0);
                        cnt_d       = '0;
                        state_d     = START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            START: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (cnt_q == NLAST_C) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                // After the last quotient beat, stay one extra cycle so that
                // done lands the cycle after the final out_valid.
                if (cnt_q != MCNT_C) begin
                    if (io.div_q_vld) begin
                        out_valid_d = 1'b1;
                        out_data_d  = io.div_q;
                        cnt_d       = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d    = '0;
                borrow_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                cnt_d    = '0;
                borrow_d = 1'b1;
                state_d  = IDLE;
            end
        endcase

`ifdef L_FUNC_WATCHDOG_EN
        if (state_q == WAIT && cnt_q != MCNT_C && !io.div_q_vld) begin
            if (wd_q == WDW'(TIMEOUT)) begin
                err_w    = 1'b1;
                cnt_d    = '0;
                borrow_d = 1'b1;
                state_d  = IDLE;
            end else begin
                wd_d = wd_q + WDW'(1);
            end
        end
`endif

        in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            borrow_q    <= 1'b1;
            underflow_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            underflow_q <= underflow_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef L_FUNC_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // Operand buffers carry no reset; their contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (x_we) begin
            x_buf_q[cnt_q[IW-1:0]] <= x_wr;
        end
        if (n_we) begin
            n_buf_q[cnt_q[JW-1:0]] <= io.in_n;
        end
    end

    always_comb begin
        io.in_ready     = in_ready_q;
        io.div_valid_in = (state_q == START);
        io.div_data_vld = (state_q == STREAM);
        io.div_dividend = '0;
        io.div_divisor  = '0;
        if (state_q == STREAM) begin
            io.div_dividend = x_buf_q[cnt_q[IW-1:0]];
            if (cnt_q < MCNT_C) begin
                io.div_divisor = n_buf_q[cnt_q[JW-1:0]];
            end
        end
        io.out_data  = out_data_q;
        io.out_valid = out_valid_q;
        io.done      = (state_q == DONE);
        io.underflow = underflow_q;
        io.err       = err_w;
    end
endmodule

// File: tb/tb_l_func_ctrl.sv
// Scoreboard bench for l_func_ctrl: the driver pushes the reference results
// ((x - 1) beats, n beats, (x - 1) / n beats, underflow) computed with wide
// arithmetic; a negedge monitor pops and compares whatever the DUT presents.
// A behavioural divider responds to the operand stream with the quotient.
module tb_l_func_ctrl;
    localparam int unsigned N = 4096, M = 2048, BLOCK = 128;
    localparam int unsigned NCNT = 32, MCNT = 16, TO = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l_func_ctrl_if #(.BLOCK(BLOCK)) io_if ();

    l_func_ctrl #(.N(N), .M(M), .BLOCK(BLOCK), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [BLOCK-1:0] act, input logic [BLOCK-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    logic [BLOCK-1:0] exp_dvd[$];
    logic [BLOCK-1:0] exp_dvs[$];
    logic [BLOCK-1:0] exp_quo[$];
    logic             exp_uf[$];

    // ---------------- monitor ----------------
    int  cyc = 0, run = 0, starts = 0, jobs_done = 0, err_seen = 0;
    int  last_stream_cyc = 0, err_cyc = 0;
    logic prev_qv = 1'b0, prev_ov = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            run = 0; starts = 0; prev_qv = 1'b0; prev_ov = 1'b0;
        end else begin
            if (io_if.div_valid_in) starts++;
            if (io_if.div_data_vld) begin
                run++;
                last_stream_cyc = cyc;
                if (exp_dvd.size() == 0) check("unexpected_stream_beat", 1, 0);
                else begin
                    check("div_dividend", io_if.div_dividend, exp_dvd.pop_front());
                    check("div_divisor", io_if.div_divisor, exp_dvs.pop_front());
                end
            end else if (run != 0) begin
                check("stream_run_length", run, NCNT);
                run = 0;
            end
            if (io_if.out_valid || prev_qv) check("out_valid_latency", io_if.out_valid, prev_qv);
            if (io_if.out_valid) begin
                if (exp_quo.size() == 0) check("unexpected_out_beat", 1, 0);
                else check("out_data", io_if.out_data, exp_quo.pop_front());
            end
            if (io_if.done) begin
                jobs_done++;
                check("done_after_last_out", prev_ov, 1);
                check("quotient_beats_left", exp_quo.size(), 0);
                check("start_pulses", starts, 1);
                check("in_ready_at_done", io_if.in_ready, 0);
                if (exp_uf.size() == 0) check("unexpected_done", 1, 0);
                else check("underflow", io_if.underflow, exp_uf.pop_front());
                starts = 0;
            end
            if (io_if.err) begin err_seen++; err_cyc = cyc; end
            prev_qv = io_if.div_q_vld;
            prev_ov = io_if.out_valid;
        end
    end

    // ---------------- divider model ----------------
    bit div_ret_en = 1'b1;
    initial begin : divider
        logic [N-1:0] xd, nd, qd;
        int beats, qi, dly;
        bit sending;
        beats = 0; qi = 0; dly = 0; sending = 1'b0;
        xd = '0; nd = '0; qd = '0;
        io_if.div_q_vld = 1'b0;
        io_if.div_q     = '0;
        forever begin
            @(posedge clk);
            #1;
            io_if.div_q_vld = 1'b0;
            if (!rst_n) begin
                beats = 0; sending = 1'b0;
            end else begin
                if (io_if.div_valid_in) begin
                    beats = 0; sending = 1'b0; xd = '0; nd = '0;
                end
                if (io_if.div_data_vld) begin
                    xd[beats*BLOCK +: BLOCK] = io_if.div_dividend;
                    nd[beats*BLOCK +: BLOCK] = io_if.div_divisor;
                    beats++;
                    if (beats == NCNT) begin
                        qd = (nd == '0) ? '0 : xd / nd;
                        qi = 0; dly = $urandom_range(1, 8); sending = 1'b1; beats = 0;
                    end
                end else if (sending && div_ret_en) begin
                    if (dly > 0) dly--;
                    else if ($urandom_range(0, 3) != 0) begin
                        io_if.div_q_vld = 1'b1;
                        io_if.div_q     = qd[qi*BLOCK +: BLOCK];
                        qi++;
                        if (qi == MCNT) sending = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // gap_mode: 0 contiguous, 1 one idle cycle before every beat, 2 random gaps
    task automatic send_job(input logic [N-1:0] x, input logic [M-1:0] n, input int gap_mode);
        logic [N-1:0] xm1, q, nw;
        bit acc;
        int t;
        xm1 = x - 1'b1;
        nw  = {{(N-M){1'b0}}, n};
        q   = xm1 / nw;
        for (int k = 0; k < NCNT; k++) begin
            exp_dvd.push_back(xm1[k*BLOCK +: BLOCK]);
            exp_dvs.push_back(k < MCNT ? nw[k*BLOCK +: BLOCK] : '0);
        end
        for (int k = 0; k < MCNT; k++) exp_quo.push_back(q[k*BLOCK +: BLOCK]);
        exp_uf.push_back(x == '0);
        for (int k = 0; k < NCNT; k++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                io_if.in_valid = 1'b0;
                io_if.in_x     = rand_wide()[BLOCK-1:0];
                @(posedge clk);
                #1;
            end
            io_if.in_valid = 1'b1;
            io_if.in_x     = x[k*BLOCK +: BLOCK];
            // beats past MCNT carry junk on in_n; the divisor must still read 0
            io_if.in_n     = (k < MCNT) ? n[k*BLOCK +: BLOCK] : ~'0;
            t = 0;
            do begin
                @(negedge clk);
                acc = io_if.in_ready;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 300);
            if (!acc) begin
                check("in_ready_timeout", 0, 1);
                k = NCNT;
            end
        end
        io_if.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int s;
        int t;
        s = jobs_done;
        t = 0;
        while (jobs_done == s && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (jobs_done == s) check("done_timeout", 0, 1);
        #1;
    endtask

    initial begin : main
        logic [M-1:0] n0;
        logic [N-1:0] x0;
        int t;
        io_if.in_valid = 1'b0;
        io_if.in_x     = '0;
        io_if.in_n     = '0;

        #12;
        check("rst_in_ready", io_if.in_ready, 0);
        check("rst_div_valid_in", io_if.div_valid_in, 0);
        check("rst_div_data_vld", io_if.div_data_vld, 0);
        check("rst_out_valid", io_if.out_valid, 0);
        check("rst_out_data", io_if.out_data, 0);
        check("rst_done", io_if.done, 0);
        check("rst_underflow", io_if.underflow, 0);
        check("rst_err", io_if.err, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_release", io_if.in_ready, 1);

        // x = 2n + 1, n = 2^2047 + 1 -> quotient 2
        n0 = '0; n0[M-1] = 1'b1; n0[0] = 1'b1;
        x0 = {{(N-M){1'b0}}, n0};
        x0 = (x0 << 1) + 1'b1;
        send_job(x0, n0, 0);
        wait_done();
        check("underflow_held_after_done", io_if.underflow, 0);

        // borrow ripple across eight beats
        x0 = '0; x0[1024] = 1'b1;
        n0 = rand_wide()[M-1:0]; n0[M-1] = 1'b1;
        send_job(x0, n0, 0);
        wait_done();

        // x = 0: full underflow, divider still run
        n0 = rand_wide()[M-1:0]; n0[M-1] = 1'b1;
        send_job('0, n0, 0);
        wait_done();
        check("underflow_held_in_idle", io_if.underflow, 1);

        // same as first job, in_valid toggling
        n0 = '0; n0[M-1] = 1'b1; n0[0] = 1'b1;
        x0 = {{(N-M){1'b0}}, n0};
        x0 = (x0 << 1) + 1'b1;
        send_job(x0, n0, 1);
        wait_done();

        for (int j = 0; j < 4; j++) begin
            n0 = rand_wide()[M-1:0]; n0[M-1] = 1'b1;
            send_job(rand_wide(), n0, 2);
            wait_done();
        end

        // reset in the middle of STREAM
        n0 = rand_wide()[M-1:0]; n0[M-1] = 1'b1;
        send_job(rand_wide(), n0, 0);
        t = 0;
        while (run < 10 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (run < 10) check("stream_start_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", io_if.in_ready, 0);
        check("midrst_div_data_vld", io_if.div_data_vld, 0);
        check("midrst_div_dividend", io_if.div_dividend, 0);
        check("midrst_div_divisor", io_if.div_divisor, 0);
        check("midrst_out_valid", io_if.out_valid, 0);
        check("midrst_done", io_if.done, 0);
        exp_dvd.delete(); exp_dvs.delete(); exp_quo.delete(); exp_uf.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = rand_wide()[M-1:0]; n0[M-1] = 1'b1;
        send_job(rand_wide(), n0, 0);
        wait_done();

`ifdef L_FUNC_WATCHDOG_EN
        begin
            int d0;
            div_ret_en = 1'b0;
            d0 = jobs_done;
            n0 = rand_wide()[M-1:0]; n0[M-1] = 1'b1;
            send_job(rand_wide(), n0, 0);
            t = 0;
            while (!io_if.err && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!io_if.err) check("err_timeout", 0, 1);
            else begin
                check("err_cycle_after_wait", cyc - last_stream_cyc, TO + 1);
                @(negedge clk);
                check("in_ready_after_err", io_if.in_ready, 1);
                check("err_single_cycle", io_if.err, 0);
            end
            check("no_done_on_abort", jobs_done - d0, 0);
            exp_quo.delete(); exp_uf.delete();
            div_ret_en = 1'b1;
            @(posedge clk);
            #1;
            n0 = rand_wide()[M-1:0]; n0[M-1] = 1'b1;
            send_job(rand_wide(), n0, 0);
            wait_done();
            check("err_pulse_count", err_seen, 1);
        end
`else
        check("err_never_asserted", err_seen, 0);
`endif

        check("jobs_completed", jobs_done, 9);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
